led_shift_out: RTL

Serializer stage that sits directly downstream of the LED pattern/counter generator. It takes the 8-bit parallel output word and shifts it MSB-first into an external 74HC595-style shift-register chain, producing data, shift-clock and latch strobes. This lets the pattern be mirrored on off-chip LEDs or displays using three pins. A valid/ready handshake accepts one word per transfer. An optional change-only mode suppresses redundant transfers.

---
 rtl/led_shift_out.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/led_shift_out.sv
// Serializes 8-bit words MSB-first into a 74HC595 chain (SER/SRCLK/RCLK); all outputs registered.
// Latency 17*DIV+2 cycles per word; pat_ready only in IDLE, duplicate words dropped there at zero latency.
module led_shift_out #(
  parameter int unsigned DIV         = 4,
  parameter bit          CHANGE_ONLY = 1'b1
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic [7:0] pat_in,
  input  logic       pat_valid,
  output logic       pat_ready,
  output logic       ser_data,
  output logic       ser_clk,
  output logic       ser_latch,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } state_t;

  localparam logic [7:0] PHASE_LAST = 8'(DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] word_q, word_d;
  logic [7:0] last_word_q, last_word_d;
  logic       last_ok_q, last_ok_d;
  logic       ready_q, ready_d;
  logic       data_q, data_d;
  logic       sclk_q, sclk_d;
  logic       latch_q, latch_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic accept;
  logic phase_end;
  logic dup_word;

  assign accept    = pat_valid && ready_q;
  assign phase_end = (cnt_q == 8'd0);
  assign dup_word  = CHANGE_ONLY && last_ok_q && (pat_in == last_word_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    word_d      = word_q;
    last_word_d = last_word_q;
    last_ok_d   = last_ok_q;
    ready_d     = ready_q;
    data_d      = data_q;
    sclk_d      = sclk_q;
    latch_d     = latch_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // A duplicate is consumed here simply by staying put with ready held high.
        if (accept && !dup_word) begin
          state_d = SHIFT_LO;
          cnt_d   = PHASE_LAST;
          idx_d   = 3'd7;
          word_d  = pat_in;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
          data_d  = pat_in[7];
        end
      end

      SHIFT_LO: begin
        if (phase_end) begin
          state_d = SHIFT_HI;
          cnt_d   = PHASE_LAST;
          sclk_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      SHIFT_HI: begin
        if (phase_end) begin
          cnt_d  = PHASE_LAST;
          sclk_d = 1'b0;
          if (idx_q == 3'd0) begin
            state_d = LATCH;
            data_d  = 1'b0;
            latch_d = 1'b1;
          end else begin
            state_d = SHIFT_LO;
            idx_d   = idx_q - 3'd1;
            data_d  = word_q[idx_q - 3'd1];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      LATCH: begin
        if (phase_end) begin
          state_d     = DONE;
          cnt_d       = PHASE_LAST;
          latch_d     = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          last_word_d = word_q;
          last_ok_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
        cnt_d   = PHASE_LAST;
        ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = PHASE_LAST;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        sclk_d  = 1'b0;
        data_d  = 1'b0;
        latch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      idx_q       <= 3'd0;
      word_q      <= 8'h00;
      last_word_q <= 8'h00;
      last_ok_q   <= 1'b0;
      ready_q     <= 1'b1;
      data_q      <= 1'b0;
      sclk_q      <= 1'b0;
      latch_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      last_word_q <= last_word_d;
      last_ok_q   <= last_ok_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
      sclk_q      <= sclk_d;
      latch_q     <= latch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pat_ready = ready_q;
  assign ser_data  = data_q;
  assign ser_clk   = sclk_q;
  assign ser_latch = latch_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
